// File: rtl/pc_sequencer.sv
// Fetch sequencer for the RV32I single-cycle core: chooses the next PC and
// handshakes instruction memory through BOOT/FETCH/WAIT/HALT.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          MAX_WAIT     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Current_PC,
    output logic [31:0] Next_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        instr_valid,
    output logic        misalign_trap,
    output logic        fetch_timeout,
    output logic [31:0] instret,
    output logic [1:0]  state
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [31:0]      instret_r;
    logic             misalign_trap_r;
    logic             fetch_timeout_r;

    logic   active_s;
    logic   retire_s;
    logic   misaligned_s;
    state_t retire_state_s;
    logic [31:0] next_pc_s;

    assign active_s     = (state_r == ST_FETCH) || (state_r == ST_WAIT);
    assign retire_s     = active_s && imem_ready && !stall;
    assign misaligned_s = redirect_valid && (redirect_target[1:0] != 2'b00);

    // A trapping retire never halts, even if the instruction also asked to.
    assign retire_state_s = (halt_req && !misaligned_s) ? ST_HALT : ST_FETCH;

    // Next PC selection; the PC only moves on reset-vector load or a retire.
    always_comb begin
        next_pc_s = Current_PC;
        case (state_r)
            ST_BOOT: next_pc_s = RESET_VECTOR;
            ST_FETCH, ST_WAIT: begin
                if (retire_s) begin
                    if (misaligned_s) begin
                        next_pc_s = TRAP_VECTOR;
                    end else if (redirect_valid) begin
                        next_pc_s = redirect_target;
                    end else begin
                        next_pc_s = Current_PC + 32'd4;
                    end
                end else begin
                    next_pc_s = Current_PC;
                end
            end
            ST_HALT: next_pc_s = Current_PC;
            default: next_pc_s = Current_PC;
        endcase
    end

    // Sequencer state, wait counter, retire counter and event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_BOOT;
            wait_cnt_r      <= '0;
            instret_r       <= 32'd0;
            misalign_trap_r <= 1'b0;
            fetch_timeout_r <= 1'b0;
        end else begin
            misalign_trap_r <= retire_s && misaligned_s;
            fetch_timeout_r <= 1'b0;
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
            case (state_r)
                ST_BOOT: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= '0;
                end
                ST_FETCH: begin
                    if (retire_s) begin
                        state_r    <= retire_state_s;
                        wait_cnt_r <= '0;
                    end else if (!imem_ready) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (retire_s) begin
                        state_r    <= retire_state_s;
                        wait_cnt_r <= '0;
                    end else if (!imem_ready) begin
                        if (wait_cnt_r == WAIT_LAST) begin
                            state_r         <= ST_HALT;
                            wait_cnt_r      <= '0;
                            fetch_timeout_r <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    wait_cnt_r <= '0;
                    if (resume) begin
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r    <= ST_BOOT;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    assign Next_PC       = next_pc_s;
    assign imem_req      = active_s;
    assign imem_addr     = Current_PC;
    assign instr_valid   = retire_s;
    assign misalign_trap = misalign_trap_r;
    assign fetch_timeout = fetch_timeout_r;
    assign instret       = instret_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a ProgramCounter model closing the loop;
// expected outputs are queued per step and popped when the outputs settle.
module tb_pc_sequencer;

    localparam logic [1:0] B = 2'b00, F = 2'b01, W = 2'b10, H = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        instr_valid;
    logic        misalign_trap;
    logic        fetch_timeout;
    logic [31:0] instret;
    logic [1:0]  state;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] npc;
        logic        req;
        logic        iv;
        logic        mt;
        logic        ft;
        logic [31:0] ir;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .Current_PC     (cur_pc),
        .Next_PC        (next_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .instr_valid    (instr_valid),
        .misalign_trap  (misalign_trap),
        .fetch_timeout  (fetch_timeout),
        .instret        (instret),
        .state          (state)
    );

    always #5 clk = ~clk;

    // ProgramCounter model: loads Next_PC every rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_pc <= 32'h0;
        else       cur_pc <= next_pc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic stl, input logic rv,
                        input logic [31:0] rt, input logic hr, input logic rs,
                        input logic [1:0] es, input logic [31:0] ea, input logic [31:0] en,
                        input logic ereq, input logic eiv, input logic emt, input logic eft,
                        input logic [31:0] eir);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        imem_ready      = rdy;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = rt;
        halt_req        = hr;
        resume          = rs;
        sb_q.push_back('{st: es, addr: ea, npc: en, req: ereq, iv: eiv, mt: emt, ft: eft, ir: eir});
        #1;
        e = sb_q.pop_front();
        chk("state",         {30'd0, state},         {30'd0, e.st});
        chk("imem_addr",     imem_addr,              e.addr);
        chk("Next_PC",       next_pc,                e.npc);
        chk("imem_req",      {31'd0, imem_req},      {31'd0, e.req});
        chk("instr_valid",   {31'd0, instr_valid},   {31'd0, e.iv});
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, e.mt});
        chk("fetch_timeout", {31'd0, fetch_timeout}, {31'd0, e.ft});
        chk("instret",       instret,                e.ir);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt_req = 1'b0; resume = 1'b0;

        // rst rdy stl rv target hr rs | state addr Next_PC req iv mt ft instret
        step(1, 0, 0, 0, 32'h0, 0, 0,  B, 32'h0, 32'h0, 0, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 32'h0, 0, 0,  B, 32'h0, 32'h0, 0, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 32'h0, 0, 0,  F, 32'h0, 32'h4, 1, 1, 0, 0, 32'd0);
        step(0, 1, 0, 0, 32'h0, 0, 0,  F, 32'h4, 32'h8, 1, 1, 0, 0, 32'd1);
        // memory wait at 0x8
        step(0, 0, 0, 0, 32'h0, 0, 0,  F, 32'h8, 32'h8, 1, 0, 0, 0, 32'd2);
        step(0, 0, 0, 0, 32'h0, 0, 0,  W, 32'h8, 32'h8, 1, 0, 0, 0, 32'd2);
        step(0, 0, 0, 0, 32'h0, 0, 0,  W, 32'h8, 32'h8, 1, 0, 0, 0, 32'd2);
        step(0, 1, 0, 0, 32'h0, 0, 0,  W, 32'h8, 32'hC, 1, 1, 0, 0, 32'd2);
        // redirects, aligned then misaligned
        step(0, 1, 0, 1, 32'h100, 0, 0, F, 32'hC,   32'h100, 1, 1, 0, 0, 32'd3);
        step(0, 1, 0, 0, 32'h0,   0, 0, F, 32'h100, 32'h104, 1, 1, 0, 0, 32'd4);
        step(0, 1, 0, 1, 32'h102, 0, 0, F, 32'h104, 32'h100, 1, 1, 0, 0, 32'd5);
        step(0, 1, 0, 0, 32'h0,   0, 0, F, 32'h100, 32'h104, 1, 1, 1, 0, 32'd6);
        step(0, 1, 1, 0, 32'h0,   0, 0, F, 32'h104, 32'h104, 1, 0, 0, 0, 32'd7);
        // misaligned redirect with halt_req: trap wins, no halt
        step(0, 1, 0, 1, 32'h201, 1, 0, F, 32'h104, 32'h100, 1, 1, 0, 0, 32'd7);
        step(0, 1, 1, 0, 32'h0,   0, 0, F, 32'h100, 32'h100, 1, 0, 1, 0, 32'd8);
        // fetch timeout: 8 not-ready cycles, one stalled-ready cycle in between
        step(0, 0, 0, 0, 32'h0, 0, 0,  F, 32'h100, 32'h100, 1, 0, 0, 0, 32'd8);
        step(0, 1, 1, 0, 32'h0, 0, 0,  W, 32'h100, 32'h100, 1, 0, 0, 0, 32'd8);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 32'h0, 0, 0, W, 32'h100, 32'h100, 1, 0, 0, 0, 32'd8);
        end
        step(0, 1, 0, 0, 32'h0, 0, 0,  H, 32'h100, 32'h100, 0, 0, 0, 1, 32'd8);
        step(0, 1, 0, 0, 32'h0, 0, 1,  H, 32'h100, 32'h100, 0, 0, 0, 0, 32'd8);
        step(0, 1, 0, 0, 32'h0, 0, 0,  F, 32'h100, 32'h104, 1, 1, 0, 0, 32'd8);
        // halt_req at 0x20
        step(0, 1, 0, 1, 32'h20, 0, 0, F, 32'h104, 32'h20, 1, 1, 0, 0, 32'd9);
        step(0, 1, 0, 0, 32'h0,  1, 0, F, 32'h20,  32'h24, 1, 1, 0, 0, 32'd10);
        step(0, 1, 0, 0, 32'h0,  0, 0, H, 32'h24,  32'h24, 0, 0, 0, 0, 32'd11);
        step(0, 1, 0, 0, 32'h0,  0, 1, H, 32'h24,  32'h24, 0, 0, 0, 0, 32'd11);
        // PC wrap and stall hold
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, F, 32'h24, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'd11);
        step(0, 1, 0, 0, 32'h0, 0, 0,  F, 32'hFFFF_FFFC, 32'h0, 1, 1, 0, 0, 32'd12);
        step(0, 1, 1, 0, 32'h0, 0, 0,  F, 32'h0, 32'h0, 1, 0, 0, 0, 32'd13);
        // reset asserted mid-WAIT, checked before the next clock edge
        step(0, 0, 0, 0, 32'h0, 0, 0,  F, 32'h0, 32'h0, 1, 0, 0, 0, 32'd13);
        step(0, 0, 0, 0, 32'h0, 0, 0,  W, 32'h0, 32'h0, 1, 0, 0, 0, 32'd13);
        step(1, 0, 0, 0, 32'h0, 0, 0,  B, 32'h0, 32'h0, 0, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 32'h0, 0, 0,  B, 32'h0, 32'h0, 0, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 32'h0, 0, 0,  F, 32'h0, 32'h4, 1, 1, 0, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
